fifo_rd_ctrl: RTL

Read-side controller for the team's asynchronous FIFO. It sits in the read clock domain across from the write-side memory and write controller. It synchronises the write pointer, owns the read pointer and the empty/level flags, and drives the memory read address. It presents popped words through a registered valid/ready output port.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/fifo_rd_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion used by both read and write controllers.
// Functions operate on a fixed wide vector; callers zero-extend in and truncate out to their pointer width.
package fifo_pkg;

  localparam int DEF_ADDR_SIZE = 4;
  localparam int PTR_W         = DEF_ADDR_SIZE + 1;
  localparam int FN_W          = 16;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser; the first stage is exposed so the consumer can see the value
// the second stage is about to load.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: syncs the write pointer, owns the read pointer and flags,
// and presents popped words through a one-entry registered valid/ready stage.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE     = DEF_ADDR_SIZE,
  parameter int DATA_SIZE     = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE:0]   wr_ptr_gray,
  input  logic [DATA_SIZE-1:0] mem_rd_data,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0]   rd_ptr_gray,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   rd_level,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] wq1, wq2;
  logic [PW-1:0] rbin, rbin_next, rgray_next;
  logic          pop;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (wr_ptr_gray),
    .q1  (wq1),
    .q   (wq2)
  );

  assign pop        = ~empty & (~out_valid | out_ready);
  assign rbin_next  = rbin + PW'(pop);
  assign rgray_next = PW'(bin2gray(FN_W'(rbin_next)));

  // empty compares next-state values so a pop and a wq2 advance on the same edge resolve together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbin        <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      rbin        <= rbin_next;
      rd_ptr_gray <= rgray_next;
      empty       <= (rgray_next == wq1);
      if (pop) begin
        out_data  <= mem_rd_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign rd_addr      = rbin[ADDR_SIZE-1:0];
  assign rd_level     = PW'(gray2bin(FN_W'(wq2))) - rbin;
  assign almost_empty = (rd_level <= PW'(AEMPTY_THRESH));

endmodule
